inst_fetch_buffer: RTL and testbench
====================================

Name: inst_fetch_buffer

Overview:
- Decoupling FIFO directly downstream of the instruction fetch stage.
- Captures each valid IF_ID_PACKET that fetch produces and presents packets in order to decode/dispatch through a valid/ready handshake.
- Throttles fetch through the existing if_valid "advance PC" input by deasserting it when full.
- Discards all contents on a pipeline flush (branch mispredict or exception).

Parameters:
- DEPTH, 8, number of packet entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: asserted when reset==0, takes effect immediately, released synchronously.
- if_packet  input  $bits(IF_ID_PACKET)  packet from fetch; fields inst, PC, NPC, valid.
- flush  input  1  squash all buffered packets this cycle.
- deq_ready  input  1  decode accepts head packet this cycle.
- if_valid  output  1  to fetch: 1 means fetch may advance PC (buffer not full).
- id_packet  output  $bits(IF_ID_PACKET)  head packet to decode.
- id_valid  output  1  id_packet holds a real instruction.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow_err  output  1  sticky: a valid packet arrived while full.

Behaviour:
- Storage: circular array of DEPTH entries, head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a separate count register. Full and empty are derived from count, never from pointer equality.
- enq = if_packet.valid && !full && !flush. deq = id_valid && deq_ready && !flush.
- Enqueue writes the entry at tail and increments tail. Dequeue increments head.
- count next value: count + enq - deq.
- Simultaneous enq and deq while non-empty and non-full: count is unchanged and both pointers advance.
- Full:
  - if_valid is 0 whenever count==DEPTH and 1 otherwise.
  - if_valid depends only on count, not on deq_ready, so there is no combinational path from decode to fetch.
  - A dequeue in the same cycle frees a slot next cycle only; an enqueue is not accepted in that cycle.
- Empty:
  - id_valid is 0 and id_packet drives all-zero with valid=0.
  - There is no bypass. A packet enqueued in cycle N is first visible on id_packet in cycle N+1 (one-cycle minimum latency).
- Otherwise id_valid is 1 and id_packet is the head entry with valid forced to 1. The head stays stable until dequeued.
- Flush:
  - Has highest priority. At the edge, head, tail and count go to 0.
  - The same-cycle if_packet is dropped and no dequeue occurs.
  - id_valid is 0 in the following cycle.
  - overflow_err is unaffected by flush.
- overflow_err:
  - Set when if_packet.valid && full && !flush.
  - Remains set until reset.
  - Fetch honouring if_valid never triggers it; it exists for verification.
- Invalid inputs: packets with if_packet.valid=0 are ignored, with no pointer or count change.
- Reset (reset==0, asynchronous, may arrive mid-operation):
  - head=0, tail=0, count=0, overflow_err=0.
  - Outputs go immediately to id_valid=0, if_valid=1, id_packet zeroed.
  - Entry storage need not be cleared.
- No combinational path from if_packet to any output.

Test Plan:
- Reset then enqueue PC 0x0, 0x4, 0x8 on consecutive cycles with deq_ready=0 -> count 1,2,3 on successive cycles; id_packet.PC=0x0 from cycle 1 and held stable; if_valid=1.
- Fill 8 packets with deq_ready=0 -> count=8, if_valid=0. Present a 9th packet with valid=1 -> not stored, overflow_err=1. Then deq_ready=1 for 8 cycles -> PCs 0x0..0x1C in order, count reaches 0, id_valid=0, if_valid returns 1 once count=7.
- Steady stream with deq_ready=1 every cycle -> count holds at 1 after the first cycle; throughput is 1 packet/cycle; order is preserved across pointer wrap after 20 packets.
- Count=5, assert flush together with a valid if_packet and deq_ready=1 -> next cycle count=0, id_valid=0; the flushed-cycle packet is not delivered; the next enqueue (PC 0x100) appears at head.
- Count=4, drive reset=0 between clock edges -> id_valid=0, count=0, if_valid=1 immediately without waiting for an edge; after release, the first enqueued packet appears one cycle later.
- Alternate if_packet.valid 1/0 with deq_ready toggling randomly for 200 cycles against a queue model -> identical output sequence, count never exceeds 8, overflow_err stays 0.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer
//   Decoupling FIFO between instruction fetch and decode/dispatch. Every
//   valid packet from fetch is captured and then handed to decode in order
//   through a valid/ready handshake. Fetch is throttled through if_valid,
//   and a flush discards everything that is buffered.
//
// Packet layout (IF_ID_PACKET, 97 bits, MSB first):
//   [96:65] inst   [64:33] PC   [32:1] NPC   [0] valid
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   if_packet     packet from fetch
//   flush         squash all buffered packets this cycle
//   deq_ready     decode accepts the head packet this cycle
//   if_valid      to fetch: 1 = PC may advance (buffer not full)
//   id_packet     head packet to decode (all zero when empty)
//   id_valid      id_packet holds a real instruction
//   count         current occupancy, 0..DEPTH
//   overflow_err  sticky: a valid packet arrived while full
module inst_fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [96:0]      if_packet,
  input  logic             flush,
  input  logic             deq_ready,
  output logic             if_valid,
  output logic [96:0]      id_packet,
  output logic             id_valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  // The valid bit is implied by occupancy, so only the payload is stored.
  logic [95:0]      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;

  // Full/empty come only from the count, so head==tail is never ambiguous.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign enq = if_packet[0] && !full && !flush;
  assign deq = !empty && deq_ready && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      overflow_err <= 1'b0;
    end else begin
      // Flush does not clear the overflow record.
      if (if_packet[0] && full && !flush) begin
        overflow_err <= 1'b1;
      end
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (enq) begin
          tail <= tail + PTR_W'(1);
        end
        if (deq) begin
          head <= head + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // Storage needs no reset; stale entries are never visible because the
  // output is gated by the count.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[tail] <= if_packet[96:1];
    end
  end

  // All outputs derive from registers only: no path from if_packet or
  // deq_ready to any output, and no same-cycle bypass.
  assign count    = count_q;
  assign if_valid = !full;
  assign id_valid = !empty;

  always_comb begin
    id_packet = '0;
    if (!empty) begin
      id_packet = {mem[head], 1'b1};
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int OBS_W = 1 + 97 + 4 + 1 + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [96:0] if_packet = '0;
  logic        flush = 1'b0;
  logic        deq_ready = 1'b0;
  logic        if_valid;
  logic [96:0] id_packet;
  logic        id_valid;
  logic [3:0]  count;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ordered list of accepted packets plus a sticky flag.
  logic [96:0] q[$];
  logic        m_ovf = 1'b0;

  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .if_packet   (if_packet),
    .flush       (flush),
    .deq_ready   (deq_ready),
    .if_valid    (if_valid),
    .id_packet   (id_packet),
    .id_valid    (id_valid),
    .count       (count),
    .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [96:0] mk_pkt(input logic [31:0] pc);
    logic [31:0] inst;
    inst = $urandom();
    return {inst, pc, pc + 32'd4, 1'b1};
  endfunction

  function automatic logic [OBS_W-1:0] model_obs();
    logic [96:0] head_pkt;
    head_pkt = '0;
    if (q.size() > 0) head_pkt = {q[0][96:1], 1'b1};
    return {q.size() > 0, head_pkt, 4'(q.size()), q.size() < DEPTH, m_ovf};
  endfunction

  function automatic logic [OBS_W-1:0] dut_obs();
    return {id_valid, id_packet, count, if_valid, overflow_err};
  endfunction

  // Apply one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic drive(input logic [96:0] pkt, input logic fl, input logic rdy);
    bit was_full;
    if_packet = pkt;
    flush     = fl;
    deq_ready = rdy;
    if (fl) begin
      q.delete();
    end else begin
      was_full = (q.size() == DEPTH);
      if (pkt[0] && was_full) m_ovf = 1'b1;
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (pkt[0] && !was_full) q.push_back(pkt);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    if_packet = '0;
    flush = 1'b0;
    deq_ready = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({id_valid, count, if_valid, overflow_err} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got id_valid=%b count=%0d if_valid=%b ovf=%b, expected 0 0 1 0",
               id_valid, count, if_valid, overflow_err);
    end
    n_checks++;
    if (id_packet !== 97'd0) begin
      n_fail++;
      $display("FAIL reset_id_packet: got %h expected 0", id_packet);
    end
  endtask

  task automatic test_fill_three();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(mk_pkt(32'(4 * i)), 1'b0, 1'b0);
      n_checks++;
      if (count !== 4'(i + 1) || id_packet[64:33] !== 32'h0 || if_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_three[%0d]: got count=%0d head_pc=%h if_valid=%b, expected %0d 0 1",
                 i, count, id_packet[64:33], if_valid, i + 1);
      end
      n_checks++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL fill_three_model[%0d]: got %h expected %h", i, dut_obs(), model_obs());
      end
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(mk_pkt(32'(4 * i)), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd8 || if_valid !== 1'b0 || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got count=%0d if_valid=%b ovf=%b, expected 8 0 0",
               count, if_valid, overflow_err);
    end
    drive(mk_pkt(32'h900), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd8 || overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got count=%0d ovf=%b, expected 8 1", count, overflow_err);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_packet[64:33] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got valid=%b pc=%h expected 1 %h",
                 i, id_valid, id_packet[64:33], 32'(4 * i));
      end
      drive('0, 1'b0, 1'b1);
      n_checks++;
      if (count !== 4'(7 - i) || if_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_count[%0d]: got count=%0d if_valid=%b expected %0d 1",
                 i, count, if_valid, 7 - i);
      end
    end
    n_checks++;
    if (id_valid !== 1'b0 || id_packet !== 97'd0 || overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL drained_empty: got valid=%b pkt=%h ovf=%b expected 0 0 1",
               id_valid, id_packet, overflow_err);
    end
  endtask

  task automatic test_stream();
    do_reset();
    drive(mk_pkt(32'h200), 1'b0, 1'b1);
    for (int i = 1; i < 20; i++) begin
      n_checks++;
      if (count !== 4'd1 || id_packet[64:33] !== 32'h200 + 32'(4 * (i - 1))) begin
        n_fail++;
        $display("FAIL stream[%0d]: got count=%0d pc=%h expected 1 %h",
                 i, count, id_packet[64:33], 32'h200 + 32'(4 * (i - 1)));
      end
      n_checks++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL stream_model[%0d]: got %h expected %h", i, dut_obs(), model_obs());
      end
      drive(mk_pkt(32'h200 + 32'(4 * i)), 1'b0, 1'b1);
    end
    drive('0, 1'b0, 1'b1);
    n_checks++;
    if (count !== 4'd0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got count=%0d valid=%b expected 0 0", count, id_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) drive(mk_pkt(32'h300 + 32'(4 * i)), 1'b0, 1'b0);
    drive(mk_pkt(32'h999), 1'b1, 1'b1);
    n_checks++;
    if (count !== 4'd0 || id_valid !== 1'b0 || id_packet !== 97'd0) begin
      n_fail++;
      $display("FAIL flush_clear: got count=%0d valid=%b pkt=%h expected 0 0 0",
               count, id_valid, id_packet);
    end
    drive(mk_pkt(32'h100), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd1 || id_packet[64:33] !== 32'h100) begin
      n_fail++;
      $display("FAIL flush_next: got count=%0d pc=%h expected 1 100", count, id_packet[64:33]);
    end
    n_checks++;
    if (dut_obs() !== model_obs()) begin
      n_fail++;
      $display("FAIL flush_model: got %h expected %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_async_reset();
    logic [96:0] p;
    do_reset();
    for (int i = 0; i < 4; i++) drive(mk_pkt(32'h500 + 32'(4 * i)), 1'b0, 1'b0);
    if_packet = '0;
    #2;
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || count !== 4'd0 || if_valid !== 1'b1 || id_packet !== 97'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b count=%0d if_valid=%b pkt=%h expected 0 0 1 0",
               id_valid, count, if_valid, id_packet);
    end
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    p = mk_pkt(32'h40);
    if_packet = p;
    #1;
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass: got id_valid=%b expected 0", id_valid);
    end
    drive(p, 1'b0, 1'b0);
    n_checks++;
    if (id_valid !== 1'b1 || id_packet !== p) begin
      n_fail++;
      $display("FAIL post_reset_enq: got valid=%b pkt=%h expected 1 %h", id_valid, id_packet, p);
    end
  endtask

  task automatic test_random();
    logic [96:0] p;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      p = {$urandom(), $urandom(), $urandom(), 1'b0};
      p[0] = (i % 2 == 0);
      drive(p, 1'b0, 1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL random_model[%0d]: got %h expected %h", i, dut_obs(), model_obs());
      end
      n_checks++;
      if (count > 4'd8 || overflow_err !== 1'b0) begin
        n_fail++;
        $display("FAIL random_bounds[%0d]: got count=%0d ovf=%b expected <=8 0",
                 i, count, overflow_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_three();
    test_full_overflow();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
